// File: rtl/peripheral_bridge_ahb3_apb4.sv
// peripheral_bridge_ahb3_apb4
//   AHB3-Lite slave to APB4 master bridge with 32-bit data and a single clock.
//   Each accepted AHB transfer becomes one APB SETUP + ACCESS sequence.
//   Illegal transfers (bad size or misaligned) get a two-cycle AHB ERROR
//   response and never reach the APB side.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL..HREADY          AHB slave inputs (HBURST/HPROT/HMASTLOCK ignored)
//   HRDATA, HREADYOUT,    AHB slave outputs
//   HRESP
//   PSEL..PWDATA          APB master outputs
//   PRDATA, PREADY,       APB completer responses
//   PSLVERR
//   dbg_state             current FSM state, for observation only
//
// Handshake: an AHB address phase is accepted when HSEL & HREADY & HTRANS[1]
// is seen in IDLE, ERR2, or the cycle an APB access completes without error.
// An APB access completes on the first ACCESS cycle with PREADY=1; while
// PREADY=0 every P* output holds its value.
module peripheral_bridge_ahb3_apb4 #(
  parameter int HADDR_SIZE = 32,
  parameter int PADDR_SIZE = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic                  PWRITE,
  output logic [3:0]            PSTRB,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t state;

  logic       sample;
  logic       illegal;
  logic       apb_done;
  logic       take;
  logic [3:0] strb_calc;

  // Bits of the AHB address above the register index, plus the sideband
  // inputs, carry no meaning for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR[HADDR_SIZE-1:PADDR_SIZE+2]};

  assign sample   = HSEL & HREADY & HTRANS[1];
  assign illegal  = (HSIZE > 3'd2)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
  assign apb_done = (state == S_ACCESS) & PREADY & ~PSLVERR;
  assign take     = sample & ((state == S_IDLE) | (state == S_ERR2) | apb_done);

  always_comb begin
    strb_calc = 4'b0000;
    if (HWRITE) begin
      case (HSIZE)
        3'd0:    strb_calc = 4'b0001 << HADDR[1:0];
        3'd1:    strb_calc = 4'b0011 << HADDR[1:0];
        default: strb_calc = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PSTRB   <= 4'b0000;
    end else begin
      case (state)
        S_SETUP: begin
          state   <= S_ACCESS;
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= PSLVERR ? S_ERR1 : S_IDLE;
          end
        end
        S_ERR1:  state <= S_ERR2;
        default: state <= S_IDLE;
      endcase

      // A newly accepted transfer overrides the default moves above.
      if (take) begin
        if (illegal) begin
          state   <= S_ERR1;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end else begin
          state   <= S_SETUP;
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          PADDR   <= HADDR[PADDR_SIZE+1:2];
          PWRITE  <= HWRITE;
          PSTRB   <= strb_calc;
        end
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_SETUP:  HREADYOUT = 1'b0;
      S_ACCESS: HREADYOUT = PREADY & ~PSLVERR;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:   HRESP = 1'b1;
      default: ;
    endcase
  end

  // AHB keeps HWDATA stable through wait states, so a direct path is enough.
  assign PWDATA    = HWDATA;
  assign HRDATA    = (state == S_ACCESS) ? PRDATA : 32'h0;
  assign dbg_state = state;

endmodule

// File: tb/tb_peripheral_bridge_ahb3_apb4.sv
module tb_peripheral_bridge_ahb3_apb4;

  localparam int HA = 32;
  localparam int PA = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic hreset;

  logic          hsel;
  logic [HA-1:0] haddr;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hmastlock;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic          psel;
  logic          penable;
  logic [PA-1:0] paddr;
  logic          pwrite;
  logic [3:0]    pstrb;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [2:0]    dbg_state;

  // Single-slave fabric: HREADY seen by the slave is its own HREADYOUT.
  assign hready = hreadyout;

  int total = 0;
  int bad   = 0;

  // expected APB payload {pwrite, paddr, pstrb, pwdata}
  logic [40:0] exp_q[$];

  peripheral_bridge_ahb3_apb4 #(.HADDR_SIZE(HA), .PADDR_SIZE(PA)) dut (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .PSEL(psel), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic bit m_legal(input int unsigned addr, input int unsigned size);
    if (size > 2) return 1'b0;
    if (size == 1 && (addr % 2) != 0) return 1'b0;
    if (size == 2 && (addr % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_strb(input int unsigned addr, input int unsigned size,
                                        input bit write);
    int unsigned v;
    if (!write) return 4'h0;
    if (size == 0)      v = 1 << (addr % 4);
    else if (size == 1) v = 3 << (addr % 4);
    else                v = 15;
    return 4'(v);
  endfunction

  function automatic logic [PA-1:0] m_index(input int unsigned addr);
    return PA'((addr / 4) % (1 << PA));
  endfunction

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer from an idle bridge; returns at posedge+1 idle.
  task automatic run_single(input logic [31:0] addr, input int size, input bit write,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, input bit err);
    logic [40:0] exp;
    int low;
    bit exp_hr;
    hsel = 1'b1; htrans = 2'd2; haddr = addr; hsize = 3'(size); hwrite = write;
    pready = 1'b0; pslverr = 1'b0; prdata = rdata;
    @(negedge clk);
    total++;
    if (hreadyout !== 1'b1) begin
      bad++; $display("FAIL addr_phase_ready got=%b exp=1", hreadyout);
    end
    step();
    hsel = 1'b0; htrans = 2'd0; hwdata = wdata;
    if (!m_legal(addr, size)) begin
      @(negedge clk);
      total++;
      if ({psel, hreadyout, hresp} !== 3'b001) begin
        bad++; $display("FAIL err1 addr=%h psel/hreadyout/hresp got=%b exp=001", addr, {psel, hreadyout, hresp});
      end
      step();
      @(negedge clk);
      total++;
      if ({psel, hreadyout, hresp} !== 3'b011) begin
        bad++; $display("FAIL err2 addr=%h psel/hreadyout/hresp got=%b exp=011", addr, {psel, hreadyout, hresp});
      end
      step();
      return;
    end
    exp = {write, m_index(addr), m_strb(addr, size, write), wdata};
    exp_q.push_back(exp);
    low = 0;
    @(negedge clk);
    if (hreadyout === 1'b0) low++;
    total++;
    if ({psel, penable, hreadyout, hrdata} !== {3'b100, 32'h0}) begin
      bad++; $display("FAIL setup_ctrl addr=%h got=%b/%h exp=100/0", addr, {psel, penable, hreadyout}, hrdata);
    end
    total++;
    if ({pwrite, paddr, pstrb, pwdata} !== exp) begin
      bad++; $display("FAIL setup_payload addr=%h got=%h exp=%h", addr, {pwrite, paddr, pstrb, pwdata}, exp);
    end
    step();
    for (int w = 0; w <= waits; w++) begin
      pready  = (w == waits);
      pslverr = err && (w == waits);
      exp_hr  = (w == waits) && !err;
      @(negedge clk);
      if (hreadyout === 1'b0) low++;
      total++;
      if ({psel, penable, hreadyout} !== {2'b11, exp_hr}) begin
        bad++; $display("FAIL access_ctrl addr=%h w=%0d got=%b exp=%b", addr, w, {psel, penable, hreadyout}, {2'b11, exp_hr});
      end
      total++;
      if ({pwrite, paddr, pstrb, pwdata} !== exp_q[0]) begin
        bad++; $display("FAIL access_payload addr=%h w=%0d got=%h exp=%h", addr, w, {pwrite, paddr, pstrb, pwdata}, exp_q[0]);
      end
      if (w == waits && !write && !err) begin
        total++;
        if (hrdata !== rdata) begin
          bad++; $display("FAIL read_data addr=%h got=%h exp=%h", addr, hrdata, rdata);
        end
      end
      step();
    end
    void'(exp_q.pop_front());
    pready = 1'b0; pslverr = 1'b0;
    if (err) begin
      @(negedge clk);
      total++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0001) begin
        bad++; $display("FAIL slverr_err1 got=%b exp=0001", {psel, penable, hreadyout, hresp});
      end
      step();
      @(negedge clk);
      total++;
      if ({psel, hreadyout, hresp} !== 3'b011) begin
        bad++; $display("FAIL slverr_err2 got=%b exp=011", {psel, hreadyout, hresp});
      end
      step();
    end else begin
      total++;
      if (low !== 1 + waits) begin
        bad++; $display("FAIL wait_count addr=%h got=%0d exp=%0d", addr, low, 1 + waits);
      end
      @(negedge clk);
      total++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin
        bad++; $display("FAIL back_to_idle got=%b exp=0010", {psel, penable, hreadyout, hresp});
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hreset = 1'b1;
    step(); step();
    @(negedge clk);
    total++;
    if ({psel, penable, paddr, pwrite, pstrb, hreadyout, hresp} !== {2'b00, 4'h0, 1'b0, 4'h0, 2'b10}) begin
      bad++; $display("FAIL reset_values got=%b", {psel, penable, paddr, pwrite, pstrb, hreadyout, hresp});
    end
    hreset = 1'b0;
    step();
  endtask

  task automatic test_word_write();
    run_single(32'h04, 2, 1'b1, 32'h0000_00A5, 32'h0, 0, 1'b0);
  endtask

  task automatic test_word_read();
    run_single(32'h0C, 2, 1'b0, 32'h0, 32'h0000_003C, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_single(32'h18, 2, 1'b1, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
  endtask

  task automatic test_unaligned();
    run_single(32'h05, 2, 1'b1, 32'h1234_5678, 32'h0, 0, 1'b0);
  endtask

  task automatic test_slverr();
    run_single(32'h08, 2, 1'b0, 32'h0, 32'h55AA_55AA, 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [40:0] ea, eb;
    ea = {1'b1, m_index(32'h1E), m_strb(32'h1E, 0, 1'b1), 32'h1111_1111};
    eb = {1'b1, m_index(32'h22), m_strb(32'h22, 1, 1'b1), 32'h2222_2222};
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    pready = 1'b1; pslverr = 1'b0;
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h1E; hsize = 3'd0; hwrite = 1'b1;
    step();
    // second address phase presented while the first is in flight
    haddr = 32'h22; hsize = 3'd1; hwdata = 32'h1111_1111;
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata} !== {3'b100, exp_q[0]}) begin
      bad++; $display("FAIL b2b_setup_a got=%h exp=%h", {psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata}, {3'b100, exp_q[0]});
    end
    step();
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata} !== {3'b111, exp_q[0]}) begin
      bad++; $display("FAIL b2b_access_a got=%h exp=%h", {psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata}, {3'b111, exp_q[0]});
    end
    void'(exp_q.pop_front());
    step();
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h2222_2222;
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata} !== {3'b100, exp_q[0]}) begin
      bad++; $display("FAIL b2b_setup_b got=%h exp=%h", {psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata}, {3'b100, exp_q[0]});
    end
    step();
    @(negedge clk);
    total++;
    if ({psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata} !== {3'b111, exp_q[0]}) begin
      bad++; $display("FAIL b2b_access_b got=%h exp=%h", {psel, penable, hreadyout, pwrite, paddr, pstrb, pwdata}, {3'b111, exp_q[0]});
    end
    void'(exp_q.pop_front());
    step();
    pready = 1'b0;
    @(negedge clk);
    total++;
    if ({psel, hreadyout} !== 2'b01) begin
      bad++; $display("FAIL b2b_idle got=%b exp=01", {psel, hreadyout});
    end
    step();
  endtask

  task automatic test_reset_in_setup();
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'd0; hreset = 1'b1;
    @(negedge clk);
    total++;
    if ({psel, hreadyout} !== 2'b10) begin
      bad++; $display("FAIL rst_pre_setup got=%b exp=10", {psel, hreadyout});
    end
    step();
    @(negedge clk);
    total++;
    if ({psel, penable, paddr, hreadyout, hresp} !== {2'b00, 4'h0, 2'b10}) begin
      bad++; $display("FAIL rst_mid_setup got=%b exp=00000010", {psel, penable, paddr, hreadyout, hresp});
    end
    hreset = 1'b0;
    step();
  endtask

  task automatic test_idle_busy();
    for (int i = 0; i < 3; i++) begin
      hsel   = (i != 2);
      htrans = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : 2'd2;
      haddr  = 32'h04; hsize = 3'd2; hwrite = 1'b1;
      step();
      @(negedge clk);
      total++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin
        bad++; $display("FAIL idle_busy i=%0d got=%b exp=0010", i, {psel, penable, hreadyout, hresp});
      end
    end
    hsel = 1'b0; htrans = 2'd0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_single(32'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), $urandom, $urandom,
                 int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; htrans = 2'd0; hmastlock = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    test_reset();
    test_word_write();
    test_word_read();
    test_back_to_back();
    test_wait_states();
    test_unaligned();
    test_slverr();
    test_reset_in_setup();
    test_idle_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
